// File: rtl/main_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// main_ctrl_fsm
// Multi-cycle MIPS main control state machine. It decodes the instruction
// opcode and sequences the datapath control signals over several cycles per
// instruction.
//
// Optional feature macro: ADDI_EN
//   defined   - opcode 8 (addi) runs DECODE -> ADDI_EXEC -> ADDI_WB -> FETCH
//   undefined - opcode 8 is handled like any other unsupported opcode
//
// The outputs are a combinational decode of the state register, so an
// asynchronous reset clears them at once. The only Mealy terms are IRWrite and
// PCWrite in FETCH (gated by mem_ready), plus illegal_op in DECODE, which is
// qualified by the IR-held opcode.
// -----------------------------------------------------------------------------
module main_ctrl_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALU_OP,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_INIT      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // True for every opcode the controller knows how to sequence.
    function automatic logic opcode_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_LW, OP_SW: ok = 1'b1;
`ifdef ADDI_EN
            OP_ADDI: ok = 1'b1;
`else
            OP_ADDI: ok = 1'b0;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t state_r;

    // State register and next-state sequencing for every instruction class.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_INIT;
        end else begin
            case (state_r)
                S_INIT: state_r <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) state_r <= S_DECODE;
                    else           state_r <= S_FETCH;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:     state_r <= S_EXECUTE;
                        OP_LW, OP_SW: state_r <= S_MEM_ADDR;
                        OP_BEQ:       state_r <= S_BRANCH;
                        OP_J:         state_r <= S_JUMP;
`ifdef ADDI_EN
                        OP_ADDI:      state_r <= S_ADDI_EXEC;
`else
                        OP_ADDI:      state_r <= S_FETCH;
`endif
                        default:      state_r <= S_FETCH;
                    endcase
                end
                // opcode is still valid here: the IR is not rewritten until FETCH
                S_MEM_ADDR: begin
                    if (opcode == OP_LW) state_r <= S_MEM_READ;
                    else                 state_r <= S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    if (mem_ready) state_r <= S_MEM_WB;
                    else           state_r <= S_MEM_READ;
                end
                S_MEM_WRITE: begin
                    if (mem_ready) state_r <= S_FETCH;
                    else           state_r <= S_MEM_WRITE;
                end
                S_EXECUTE:   state_r <= S_R_WB;
                S_MEM_WB:    state_r <= S_FETCH;
                S_R_WB:      state_r <= S_FETCH;
                S_BRANCH:    state_r <= S_FETCH;
                S_JUMP:      state_r <= S_FETCH;
`ifdef ADDI_EN
                S_ADDI_EXEC: state_r <= S_ADDI_WB;
                S_ADDI_WB:   state_r <= S_FETCH;
`endif
                default:     state_r <= S_INIT;
            endcase
        end
    end

    // Datapath control decode of the current state; unlisted outputs stay 0.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALU_OP      = 2'b00;
        illegal_op  = 1'b0;
        case (state_r)
            S_FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = 2'b01;
                IRWrite  = mem_ready;
                PCWrite  = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = ~opcode_supported(opcode);
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALU_OP  = 2'b10;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALU_OP      = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
`ifdef ADDI_EN
            S_ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDI_WB: begin
                RegWrite = 1'b1;
            end
`endif
            default: begin
                PCWrite = 1'b0;
            end
        endcase
    end

    assign state = state_r;

endmodule
